// File: rtl/mux4_scan_ctrl_pkg.sv
// mux4_scan_pkg: shared types and constants for the 4:1 mux scan sequencer.
//   state_e  - sequencer FSM states
//   CH_A..D  - {s1,s0} select codes for channels a..d
//   cnt_w()  - width of the dwell down-counter for a given DWELL
package mux4_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;

   function automatic int cnt_w(input int dwell);
      return $clog2(dwell + 1);
   endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// mux4_scan_ctrl_if: control/data bundle between the scan sequencer and its user.
//   master (user side) drives start, continuous, chan_mask, mux_out
//   slave  (sequencer) drives s0, s1, sample, sample_valid, busy
interface mux4_scan_ctrl_if;
   logic       start;
   logic       continuous;
   logic [3:0] chan_mask;
   logic       mux_out;
   logic       s0;
   logic       s1;
   logic [3:0] sample;
   logic       sample_valid;
   logic       busy;

   modport master (
      output start, continuous, chan_mask, mux_out,
      input  s0, s1, sample, sample_valid, busy
   );

   modport slave (
      input  start, continuous, chan_mask, mux_out,
      output s0, s1, sample, sample_valid, busy
   );
endinterface

// File: rtl/mux4_scan_ctrl_next_chan.sv
// mux4_next_chan: combinational priority finder over the 4-channel mask.
//   mask  - enabled channels
//   cur   - current channel (ignored when first=1)
//   first - 1: lowest enabled channel; 0: lowest enabled channel above cur
//   nxt   - selected channel (CH_A when none found)
//   found - a qualifying channel exists
module mux4_next_chan
   import mux4_scan_pkg::*;
(
   input  logic [3:0] mask,
   input  logic [1:0] cur,
   input  logic       first,
   output logic [1:0] nxt,
   output logic       found
);

   always_comb begin
      nxt   = CH_A;
      found = 1'b0;
      // Walk downward so the lowest qualifying channel is the last one written.
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (first || (2'(i) > cur))) begin
            nxt   = 2'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: time-division scanner in front of a 4:1 mux.
// Steps {s1,s0} through the enabled channels, holding each for DWELL cycles
// and sampling mux_out on the last one, then reports the 4-bit snapshot with
// a one-cycle sample_valid.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of mux4_scan_ctrl_if (start/continuous/chan_mask/
//              mux_out in; s0/s1/sample/sample_valid/busy out, all registered)
module mux4_scan_ctrl
   import mux4_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst,
   mux4_scan_ctrl_if.slave  bus
);

   localparam int            CW     = cnt_w(DWELL);
   localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

   state_e        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    mask_q, mask_d;
   logic [3:0]    acc_q, acc_d;
   logic [3:0]    sample_q, sample_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;

   logic [1:0]    first_ch, next_ch;
   logic          first_found, next_found;

   // Lowest enabled channel of the live mask, used whenever a sweep is latched.
   mux4_next_chan u_first (
      .mask  (bus.chan_mask),
      .cur   (CH_A),
      .first (1'b1),
      .nxt   (first_ch),
      .found (first_found)
   );

   // Next enabled channel above the current one, from the latched mask.
   mux4_next_chan u_adv (
      .mask  (mask_q),
      .cur   (sel_q),
      .first (1'b0),
      .nxt   (next_ch),
      .found (next_found)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      acc_d    = acc_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && first_found) begin
               mask_d  = bus.chan_mask;
               acc_d   = '0;
               sel_d   = first_ch;
               cnt_d   = RELOAD;
               state_d = ST_DWELL;
               busy_d  = 1'b1;
            end
         end
         ST_DWELL: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               acc_d[sel_q] = bus.mux_out;
               if (next_found) begin
                  sel_d = next_ch;
                  cnt_d = RELOAD;
               end else begin
                  // Publish on the exit edge so sample and sample_valid
                  // appear together during the DONE cycle.
                  sample_d = acc_d;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (bus.continuous && first_found) begin
               mask_d  = bus.chan_mask;
               acc_d   = '0;
               sel_d   = first_ch;
               cnt_d   = RELOAD;
               state_d = ST_DWELL;
               busy_d  = 1'b1;
            end else begin
               sel_d   = CH_A;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            sel_d   = CH_A;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= CH_A;
         cnt_q    <= '0;
         mask_q   <= '0;
         acc_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         acc_q    <= acc_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.s0           = sel_q[0];
   assign bus.s1           = sel_q[1];
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.busy         = busy_q;

endmodule
